disp_out_ex: RTL

- Parametrised display output stage; successor to the fixed 640x480 RGB888 output block.
- Sits between the pixel FIFO (fed by the VRAM AXI reader) and the video encoder. Consumes HCNT/VCNT from the sync generator.
- Adds generic timing and colour depth, per-line pixel format modes and horizontal pixel doubling.
- Adds background colour for display-off lines, FIFO underflow detection and a single-cycle frame-start pulse.

---
 rtl/disp_out_ex.sv | 120 ++++++++++++
 1 files changed

// File: rtl/disp_out_ex.sv
// Display output stage: per-line format/doubling/enable, 2-cycle FIFO-to-pixel pipeline,
// background fill on display-off or underflow, and a per-frame fetch-start pulse.
module disp_out_ex #(
  parameter int HPERIOD = 800,
  parameter int HFRONT  = 16,
  parameter int HWIDTH  = 96,
  parameter int HBACK   = 48,
  parameter int VPERIOD = 525,
  parameter int VFRONT  = 10,
  parameter int VWIDTH  = 2,
  parameter int VBACK   = 33,
  parameter int CW      = 10,
  parameter int CD      = 8
) (
  input  logic            PCK,
  input  logic            PRST,
  input  logic            DISPON,
  input  logic [1:0]      MODE,
  input  logic            HDOUBLE,
  input  logic [3*CD-1:0] BGCOLOR,
  output logic            FIFORD,
  input  logic [3*CD-1:0] FIFOOUT,
  input  logic            FIFOEMPTY,
  input  logic [CW-1:0]   HCNT,
  input  logic [CW-1:0]   VCNT,
  input  logic            UFCLR,
  output logic            UNDERFLOW,
  output logic            AXISTART,
  output logic [CD-1:0]   VGA_R,
  output logic [CD-1:0]   VGA_G,
  output logic [CD-1:0]   VGA_B,
  output logic            VGA_DE
);
  localparam int HBLANK = HFRONT + HWIDTH + HBACK;
  localparam int VBLANK = VFRONT + VWIDTH + VBACK;
  localparam logic [CW-1:0] H_LS   = CW'(HBLANK - 3);
  localparam logic [CW-1:0] H_WEND = CW'(HPERIOD - 4);
  localparam logic [CW-1:0] H_LAST = CW'(HPERIOD - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(VBLANK);
  localparam logic [CW-1:0] V_AX   = CW'(VBLANK - 2);

  function automatic logic [CD-1:0] rep5(input logic [4:0] v);
    rep5 = '0;
    for (int i = 0; i < CD; i++) rep5[CD-1-i] = v[4 - (i % 5)];
  endfunction

  function automatic logic [CD-1:0] rep6(input logic [5:0] v);
    rep6 = '0;
    for (int i = 0; i < CD; i++) rep6[CD-1-i] = v[5 - (i % 6)];
  endfunction

  function automatic logic [3*CD-1:0] fmt(input logic [1:0] m, input logic [3*CD-1:0] d);
    case (m)
      2'd1:    fmt = {rep5(d[15:11]), rep6(d[10:5]), rep5(d[4:0])};
      2'd2:    fmt = {3{d[CD-1:0]}};
      default: fmt = d;
    endcase
  endfunction

  logic            active, ls, win_n;
  logic            dispon_l, hdouble_l;
  logic [1:0]      mode_l;
  logic            dispon_c, hdouble_c;
  logic [CW-1:0]   hofs;
  logic            win_q, de1, rd_d, uf_d;
  logic [3*CD-1:0] hold_q, px;

  assign active    = VCNT >= V_ACT;
  assign ls        = active && (HCNT == H_LS);
  // Controls are taken straight from the inputs on the latch cycle so the first read lines up.
  assign dispon_c  = ls ? DISPON  : dispon_l;
  assign hdouble_c = ls ? HDOUBLE : hdouble_l;
  assign win_n     = active && (HCNT >= H_LS) && (HCNT <= H_WEND);
  assign hofs      = HCNT - H_LS;

  always_comb begin
    px = hold_q;
    if (!dispon_l)  px = BGCOLOR;
    else if (rd_d)  px = uf_d ? BGCOLOR : fmt(mode_l, FIFOOUT);
  end

  always_ff @(posedge PCK) begin
    if (PRST) begin
      dispon_l  <= 1'b0;
      mode_l    <= 2'd0;
      hdouble_l <= 1'b0;
      win_q     <= 1'b0;
      de1       <= 1'b0;
      FIFORD    <= 1'b0;
      rd_d      <= 1'b0;
      uf_d      <= 1'b0;
      UNDERFLOW <= 1'b0;
      AXISTART  <= 1'b0;
      hold_q    <= '0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      VGA_DE    <= 1'b0;
    end else begin
      if (ls) begin
        dispon_l  <= DISPON;
        mode_l    <= MODE;
        hdouble_l <= HDOUBLE;
      end
      win_q  <= win_n;
      de1    <= win_q;
      // Doubled lines read on even window offsets; the odd slot replays hold_q.
      FIFORD <= win_n && dispon_c && (!hdouble_c || !hofs[0]);
      rd_d   <= FIFORD;
      uf_d   <= FIFORD && FIFOEMPTY;
      if (FIFORD && FIFOEMPTY) UNDERFLOW <= 1'b1;
      else if (UFCLR)          UNDERFLOW <= 1'b0;
      // Registered one cycle early so the pulse is visible during HCNT==0 of line VBLANK-1.
      AXISTART <= (HCNT == H_LAST) && (VCNT == V_AX);
      if (de1) hold_q <= px;
      {VGA_R, VGA_G, VGA_B} <= de1 ? px : '0;
      VGA_DE <= de1;
    end
  end
endmodule
